// File: rtl/echo_delay_fx.sv
// Feedback echo for the playback sample path: each accepted sample is mixed with the
// sample written delay_len samples earlier, and a gain-scaled copy is fed back into the line.
module echo_delay_fx #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned GAIN_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     song_done,
  input  logic                     enable,
  input  logic [ADDR_W-1:0]        delay_len,
  input  logic [GAIN_W-1:0]        fb_gain,
  input  logic [GAIN_W-1:0]        mix_gain,
  input  logic                     sample_in_ready,
  input  logic signed [WIDTH-1:0]  sample_in,
  output logic signed [WIDTH-1:0]  sample_out,
  output logic                     sample_out_ready
);

  localparam int unsigned PW    = WIDTH + GAIN_W + 1;
  localparam int unsigned Depth = 2 ** ADDR_W;

  typedef enum logic [1:0] {StIdle, StRd, StMac, StOut} state_e;

  state_e                   state_q, state_d;
  logic [ADDR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]        fill_q, fill_d;
  logic [ADDR_W-1:0]        rd_addr_q, rd_addr_d;
  logic signed [WIDTH-1:0]  x_q, x_d;
  logic [GAIN_W-1:0]        mix_q, mix_d;
  logic [GAIN_W-1:0]        fb_q, fb_d;
  logic                     echo_on_q, echo_on_d;
  logic signed [PW-1:0]     pm_q, pm_d;
  logic signed [PW-1:0]     pf_q, pf_d;
  logic signed [WIDTH-1:0]  out_q, out_d;
  logic                     out_rdy_q, out_rdy_d;
  logic [WIDTH-1:0]         rd_data_q;
  logic [WIDTH-1:0]         line_mem [Depth];

  logic                     mem_we;
  logic [WIDTH-1:0]         mem_wdata;
  logic signed [PW-1:0]     d_ext, mix_ext, fb_ext, x_ext, sum_out, sum_fb;

  function automatic logic signed [WIDTH-1:0] sat(input logic signed [PW-1:0] v);
    logic signed [PW-1:0] hi, lo;
    hi = $signed({{(PW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}});
    lo = $signed({{(PW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}});
    if (v > hi)      return $signed(hi[WIDTH-1:0]);
    else if (v < lo) return $signed(lo[WIDTH-1:0]);
    else             return $signed(v[WIDTH-1:0]);
  endfunction

  always_comb begin
    // Stale RAM contents are masked by the echo_on gate latched at accept time.
    d_ext   = echo_on_q ? $signed({{(PW-WIDTH){rd_data_q[WIDTH-1]}}, rd_data_q}) : '0;
    mix_ext = $signed({{(PW-GAIN_W){1'b0}}, mix_q});
    fb_ext  = $signed({{(PW-GAIN_W){1'b0}}, fb_q});
    x_ext   = $signed({{(PW-WIDTH){x_q[WIDTH-1]}}, x_q});
    sum_out = x_ext + (pm_q >>> GAIN_W);
    sum_fb  = x_ext + (pf_q >>> GAIN_W);
  end

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    fill_d    = fill_q;
    rd_addr_d = rd_addr_q;
    x_d       = x_q;
    mix_d     = mix_q;
    fb_d      = fb_q;
    echo_on_d = echo_on_q;
    pm_d      = pm_q;
    pf_d      = pf_q;
    out_d     = out_q;
    out_rdy_d = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = sat(sum_fb);

    unique case (state_q)
      StIdle: begin
        if (sample_in_ready) begin
          x_d       = sample_in;
          mix_d     = mix_gain;
          fb_d      = fb_gain;
          rd_addr_d = wr_ptr_q - delay_len;
          echo_on_d = enable && (delay_len != '0) && (fill_q >= delay_len);
          state_d   = StRd;
        end
      end
      StRd:  state_d = StMac;
      StMac: begin
        pm_d    = d_ext * mix_ext;
        pf_d    = d_ext * fb_ext;
        state_d = StOut;
      end
      StOut: begin
        out_d     = sat(sum_out);
        out_rdy_d = 1'b1;
        mem_we    = 1'b1;
        wr_ptr_d  = wr_ptr_q + ADDR_W'(1);
        fill_d    = (fill_q == {ADDR_W{1'b1}}) ? fill_q : fill_q + ADDR_W'(1);
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Clearing aborts any in-flight sample, including its line write.
    if (reset || song_done) begin
      state_d   = StIdle;
      wr_ptr_d  = '0;
      fill_d    = '0;
      out_d     = '0;
      out_rdy_d = 1'b0;
      mem_we    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      wr_ptr_q  <= '0;
      fill_q    <= '0;
      rd_addr_q <= '0;
      x_q       <= '0;
      mix_q     <= '0;
      fb_q      <= '0;
      echo_on_q <= 1'b0;
      pm_q      <= '0;
      pf_q      <= '0;
      out_q     <= '0;
      out_rdy_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      fill_q    <= fill_d;
      rd_addr_q <= rd_addr_d;
      x_q       <= x_d;
      mix_q     <= mix_d;
      fb_q      <= fb_d;
      echo_on_q <= echo_on_d;
      pm_q      <= pm_d;
      pf_q      <= pf_d;
      out_q     <= out_d;
      out_rdy_q <= out_rdy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) line_mem[wr_ptr_q] <= mem_wdata;
    if (state_q == StRd) rd_data_q <= line_mem[rd_addr_q];
  end

  assign sample_out       = out_q;
  assign sample_out_ready = out_rdy_q;

endmodule

// File: tb/tb_echo_delay_fx.sv
// Randomized bench for echo_delay_fx with a small-depth line so pointer wrap is exercised;
// the reference model keeps the full history of line writes in a queue.
module tb_echo_delay_fx;

  localparam int unsigned AW = 4;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                song_done = 1'b0;
  logic                enable = 1'b1;
  logic [AW-1:0]       delay_len = '0;
  logic [7:0]          fb_gain = '0;
  logic [7:0]          mix_gain = '0;
  logic                sample_in_ready = 1'b0;
  logic signed [15:0]  sample_in = '0;
  logic signed [15:0]  sample_out;
  logic                sample_out_ready;

  int n_checks = 0;
  int n_errs   = 0;
  int hist[$];
  int outs[$];

  echo_delay_fx #(.WIDTH(16), .ADDR_W(AW), .GAIN_W(8)) dut (
    .clk              (clk),
    .reset            (reset),
    .song_done        (song_done),
    .enable           (enable),
    .delay_len        (delay_len),
    .fb_gain          (fb_gain),
    .mix_gain         (mix_gain),
    .sample_in_ready  (sample_in_ready),
    .sample_in        (sample_in),
    .sample_out       (sample_out),
    .sample_out_ready (sample_out_ready)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int sat16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Echo source is the line write made delay_len samples ago, if that many exist since clear.
  task automatic model_step(input int x, output int y);
    int n, d, dl;
    n  = hist.size();
    dl = int'(delay_len);
    d  = 0;
    if (enable && dl != 0 && n >= dl) d = hist[n - dl];
    y = sat16(x + ((d * int'(mix_gain)) >>> 8));
    hist.push_back(sat16(x + ((d * int'(fb_gain)) >>> 8)));
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    hist.delete();
    outs.delete();
    check_eq("reset_out", int'(sample_out), 0);
    check_eq("reset_rdy", int'(sample_out_ready), 0);
  endtask

  // mode 0: normal, 1: extra strobe while busy, 2: song_done during MAC
  task automatic send(input int x, input int mode);
    int exp_y, lat, nstr, got;
    lat = 0; nstr = 0; got = 0; exp_y = 0;
    if (mode != 2) model_step(x, exp_y);
    @(posedge clk); #1;
    sample_in       = 16'(x);
    sample_in_ready = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      if (k == 1) sample_in_ready = 1'b0;
      if (mode == 1 && k == 2) begin
        sample_in       = ~sample_in;
        sample_in_ready = 1'b1;
      end
      if (mode == 1 && k == 3) sample_in_ready = 1'b0;
      if (mode == 2 && k == 2) song_done = 1'b1;
      if (mode == 2 && k == 3) song_done = 1'b0;
      if (sample_out_ready) begin
        nstr++;
        if (lat == 0) begin
          lat = k;
          got = int'(sample_out);
        end
      end
    end
    if (mode == 2) begin
      check_eq("abort_strobes", nstr, 0);
      hist.delete();
    end else begin
      check_eq("latency", lat, 4);
      check_eq("strobe_cnt", nstr, 1);
      check_eq("sample_out", got, exp_y);
      check_eq("hold", int'(sample_out), exp_y);
      outs.push_back(got);
    end
  endtask

  function automatic int rnd_x();
    return int'($urandom_range(65535)) - 32768;
  endfunction

  initial begin
    int x;
    do_reset();

    // Impulse, single echo
    enable = 1'b1; delay_len = 4'd4; mix_gain = 8'd128; fb_gain = 8'd0;
    send(1000, 0);
    for (int i = 0; i < 11; i++) send(0, 0);
    check_eq("single_echo_4", outs[4], 500);
    check_eq("single_echo_8", outs[8], 0);

    // Decaying echoes with floor rounding
    do_reset();
    fb_gain = 8'd128;
    send(1000, 0);
    for (int i = 0; i < 16; i++) send(0, 0);
    check_eq("decay_8", outs[8], 250);
    check_eq("decay_12", outs[12], 125);
    check_eq("decay_16", outs[16], 62);
    do_reset();
    send(-1000, 0);
    for (int i = 0; i < 16; i++) send(0, 0);
    check_eq("neg_decay_16", outs[16], -63);

    // Saturation
    do_reset();
    delay_len = 4'd1; mix_gain = 8'd255; fb_gain = 8'd255;
    for (int i = 0; i < 4; i++) send(30000, 0);
    check_eq("sat_pos", outs[3], 32767);
    for (int i = 0; i < 4; i++) send(-30000, 0);
    check_eq("sat_neg", outs[7], -32768);

    // Fill gating then wrap with max delay
    do_reset();
    delay_len = 4'd15; mix_gain = 8'd200; fb_gain = 8'd100;
    for (int i = 0; i < 20; i++) send(rnd_x() / 4, 0);
    do_reset();
    delay_len = 4'd0;
    for (int i = 0; i < 20; i++) send(rnd_x(), 0);
    delay_len = 4'd15;
    for (int i = 0; i < 24; i++) send(rnd_x() / 2, 0);

    // song_done during MAC with an echo tail running
    delay_len = 4'd3; mix_gain = 8'd180; fb_gain = 8'd200;
    for (int i = 0; i < 6; i++) send(rnd_x(), 0);
    send(1234, 2);
    for (int i = 0; i < 6; i++) send(rnd_x(), 0);

    // Extra strobe while busy is dropped; bypass is bit-exact
    send(777, 1);
    send(-555, 0);
    enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      x = rnd_x();
      send(x, 0);
      check_eq("bypass", outs[outs.size() - 1], x);
    end

    // Randomized controls and data
    for (int blk = 0; blk < 20; blk++) begin
      enable    = ($urandom_range(3) != 0);
      delay_len = AW'($urandom_range(15));
      mix_gain  = 8'($urandom_range(255));
      fb_gain   = 8'($urandom_range(255));
      for (int i = 0; i < 10; i++) begin
        int m;
        m = $urandom_range(19);
        send(rnd_x(), (m == 0) ? 2 : (m == 1) ? 1 : 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
